// File: rtl/bank_timing_tracker_pkg.sv
// types_def: shared command/bank-state types and default DRAM timing constants
package types_def;

    typedef enum logic [2:0] {
        activate,
        read_cmd,
        write_cmd,
        precharge,
        none,
        refresh_all
    } cmd_type;

    typedef enum logic [2:0] {
        B_IDLE,
        B_ACTIVATING,
        B_ACTIVE,
        B_PRECHARGING,
        B_REFRESHING
    } bank_state_type;

    localparam int DEF_BG_NO        = 4;
    localparam int DEF_BANKS_PER_BG = 4;
    localparam int DEF_ROW_W        = 16;
    localparam int DEF_T_RCD        = 4;
    localparam int DEF_T_RP         = 4;
    localparam int DEF_T_RAS        = 10;
    localparam int DEF_T_CCD_L      = 4;
    localparam int DEF_T_CCD_S      = 2;
    localparam int DEF_T_RFC        = 20;

    function automatic int ctr_width(input int a, input int b, input int c,
                                     input int d, input int e, input int f);
        int m;
        m = (a > b) ? a : b;
        m = (c > m) ? c : m;
        m = (d > m) ? d : m;
        m = (e > m) ? e : m;
        m = (f > m) ? f : m;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/bank_timing_tracker_bank_fsm.sv
// bank_fsm: one bank's state, wait counter, tRAS counter and open row
module bank_fsm
    import types_def::*;
#(
    parameter int ROW_W = 16,
    parameter int CW    = 5,
    parameter int T_RCD = 4,
    parameter int T_RP  = 4,
    parameter int T_RAS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             act_i,
    input  logic             pre_i,
    input  logic             ref_i,
    input  logic             ref_done_i,
    input  logic [ROW_W-1:0] row_i,
    output bank_state_type   state_o,
    output logic             ras_zero_o,
    output logic [ROW_W-1:0] row_o
);

    bank_state_type   state_q, state_d;
    logic [CW-1:0]    t_q, t_d, ras_q, ras_d;
    logic [ROW_W-1:0] row_q, row_d;

    // Accepted commands win; otherwise a wait state ends on the edge its counter hits 0
    always_comb begin
        state_d = state_q;
        t_d     = (t_q != '0) ? t_q - 1'b1 : '0;
        ras_d   = (ras_q != '0) ? ras_q - 1'b1 : '0;
        row_d   = row_q;
        if (act_i) begin
            state_d = (T_RCD == 1) ? B_ACTIVE : B_ACTIVATING;
            t_d     = CW'(T_RCD - 1);
            ras_d   = CW'(T_RAS - 1);
            row_d   = row_i;
        end else if (pre_i) begin
            state_d = (T_RP == 1) ? B_IDLE : B_PRECHARGING;
            t_d     = CW'(T_RP - 1);
        end else if (ref_i) begin
            state_d = B_REFRESHING;
        end else if (state_q == B_ACTIVATING && t_q <= CW'(1)) begin
            state_d = B_ACTIVE;
        end else if (state_q == B_PRECHARGING && t_q <= CW'(1)) begin
            state_d = B_IDLE;
        end else if (state_q == B_REFRESHING && ref_done_i) begin
            state_d = B_IDLE;
        end
    end

    // Bank state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= B_IDLE;
            t_q     <= '0;
            ras_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            ras_q   <= ras_d;
            row_q   <= row_d;
        end
    end

    assign state_o    = state_q;
    assign ras_zero_o = (ras_q == '0);
    assign row_o      = row_q;

endmodule

// File: rtl/bank_timing_tracker.sv
// bank_timing_tracker: per-bank state/timing tracking with legality masks for the scheduler
module bank_timing_tracker
    import types_def::*;
#(
    parameter int BG_NO        = DEF_BG_NO,
    parameter int BANKS_PER_BG = DEF_BANKS_PER_BG,
    parameter int ROW_W        = DEF_ROW_W,
    parameter int T_RCD        = DEF_T_RCD,
    parameter int T_RP         = DEF_T_RP,
    parameter int T_RAS        = DEF_T_RAS,
    parameter int T_CCD_L      = DEF_T_CCD_L,
    parameter int T_CCD_S      = DEF_T_CCD_S,
    parameter int T_RFC        = DEF_T_RFC
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    cmd_valid,
    input  cmd_type                                 cmd,
    input  logic [$clog2(BG_NO)-1:0]                cmd_bg,
    input  logic [$clog2(BANKS_PER_BG)-1:0]         cmd_bank,
    input  logic [ROW_W-1:0]                        cmd_row,
    output logic [BG_NO*BANKS_PER_BG-1:0]           act_ok,
    output logic [BG_NO*BANKS_PER_BG-1:0]           rdwr_ok,
    output logic [BG_NO*BANKS_PER_BG-1:0]           pre_ok,
    output logic                                    ref_ok,
    output logic [BG_NO*BANKS_PER_BG-1:0]           bank_open,
    output logic [BG_NO*BANKS_PER_BG*ROW_W-1:0]     open_row,
    output logic                                    cmd_err
);

    localparam int NUM_BANKS = BG_NO * BANKS_PER_BG;
    localparam int BW        = $clog2(NUM_BANKS);
    localparam int CW        = ctr_width(T_RCD, T_RP, T_RAS, T_CCD_L, T_CCD_S, T_RFC);
    localparam bit REF_WAIT  = (T_RFC > 1);

    bank_state_type        st [NUM_BANKS];
    logic [NUM_BANKS-1:0]  ras_zero, act_v, pre_v;
    logic [CW-1:0]         ccd_l_q [BG_NO];
    logic [CW-1:0]         ccd_l_d [BG_NO];
    logic [CW-1:0]         ccd_s_q, ccd_s_d, rfc_q, rfc_d;
    logic                  err_q, err_d, legal, go, rw_go, ref_go;
    logic [BW-1:0]         b;

    assign b = BW'(int'(cmd_bg) * BANKS_PER_BG + int'(cmd_bank));

    // Legality of the presented command against the registered ok masks
    always_comb begin
        legal = (cmd == activate) ? act_ok[b] :
                (cmd == read_cmd || cmd == write_cmd) ? rdwr_ok[b] :
                (cmd == precharge) ? pre_ok[b] :
                (cmd == refresh_all) ? ref_ok : 1'b1;
    end

    assign go     = cmd_valid && legal;
    assign err_d  = cmd_valid && !legal;
    assign rw_go  = go && (cmd == read_cmd || cmd == write_cmd);
    assign ref_go = go && (cmd == refresh_all);
    assign ref_ok = &act_ok;

    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
        assign act_v[i]     = go && cmd == activate && b == BW'(i);
        assign pre_v[i]     = go && cmd == precharge && b == BW'(i);
        assign act_ok[i]    = (st[i] == B_IDLE);
        assign rdwr_ok[i]   = (st[i] == B_ACTIVE) && ccd_l_q[i / BANKS_PER_BG] == '0 && ccd_s_q == '0;
        assign pre_ok[i]    = (st[i] == B_ACTIVE) && ras_zero[i];
        assign bank_open[i] = (st[i] == B_ACTIVATING) || (st[i] == B_ACTIVE);
        bank_fsm #(
            .ROW_W (ROW_W),
            .CW    (CW),
            .T_RCD (T_RCD),
            .T_RP  (T_RP),
            .T_RAS (T_RAS)
        ) u_bank (
            .clk        (clk),
            .rst        (rst),
            .act_i      (act_v[i]),
            .pre_i      (pre_v[i]),
            .ref_i      (ref_go && REF_WAIT),
            .ref_done_i (rfc_q == CW'(1)),
            .row_i      (cmd_row),
            .state_o    (st[i]),
            .ras_zero_o (ras_zero[i]),
            .row_o      (open_row[i*ROW_W +: ROW_W])
        );
    end

    // Shared column spacing and refresh counters, all saturating at zero
    always_comb begin
        ccd_s_d = rw_go ? CW'(T_CCD_S - 1) : ((ccd_s_q != '0) ? ccd_s_q - 1'b1 : '0);
        rfc_d   = ref_go ? CW'(T_RFC - 1) : ((rfc_q != '0) ? rfc_q - 1'b1 : '0);
        for (int g = 0; g < BG_NO; g++)
            ccd_l_d[g] = (rw_go && int'(cmd_bg) == g) ? CW'(T_CCD_L - 1) :
                         ((ccd_l_q[g] != '0) ? ccd_l_q[g] - 1'b1 : '0);
    end

    // Shared counter and error pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int g = 0; g < BG_NO; g++) ccd_l_q[g] <= '0;
            ccd_s_q <= '0;
            rfc_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            ccd_l_q <= ccd_l_d;
            ccd_s_q <= ccd_s_d;
            rfc_q   <= rfc_d;
            err_q   <= err_d;
        end
    end

    assign cmd_err = err_q;

endmodule
